mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous 256x16 program/data memory between two requesters: the CPU (control unit plus execution unit) and a debug/loader port used for program download and memory inspection.
- Arbitrates requests, sequences each memory access, and returns read data to the winning requester.
- Sits between both requesters and the memory, replacing the direct CPU-to-memory connection.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 16, memory data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_req  in  1  CPU access request; held high until cpu_gnt is seen.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted.
- cpu_rvalid  out  1  one-cycle pulse: rdata holds CPU read result.
- dbg_req  in  1  debug access request; held high until dbg_gnt is seen.
- dbg_we  in  1  debug write (1) / read (0).
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_lock  in  1  1 = CPU is locked out; only debug is granted.
- dbg_gnt  out  1  one-cycle pulse: debug request accepted.
- dbg_rvalid  out  1  one-cycle pulse: rdata holds debug read result.
- rdata  out  DATA_W  registered read data, shared by both requesters.
- mem_en  out  1  memory access enable (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid the cycle after an mem_en read.
- busy  out  1  1 when the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including rdata.
  - last_gnt goes to DBG, so the CPU wins the first tie.
  - Any in-flight access is abandoned; no rvalid is issued afterwards.
- States: IDLE, GNT, RD.
- IDLE:
  - Eligible requesters are cpu_req & ~dbg_lock, and dbg_req.
  - If none is eligible, stay in IDLE.
  - If one is eligible, it wins.
  - If both are eligible, the winner is the requester that is not last_gnt (round-robin).
  - At the clock edge: latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_en=1 and the winner's gnt=1, update last_gnt, record the owner, and go to GNT.
- GNT (1 cycle):
  - mem_en=1 and the owner's gnt=1. All other gnt/mem_en cycles are 0.
  - Write: go to IDLE at the next edge.
  - Read: go to RD at the next edge.
- RD (1 cycle):
  - mem_en=0; mem_rdata is valid.
  - At the edge: capture rdata<=mem_rdata, pulse the owner's rvalid for the following cycle, go to IDLE.
- Latency and throughput:
  - gnt is asserted 1 cycle after req is sampled in IDLE.
  - Read: rvalid is asserted 3 cycles after req is sampled.
  - Write commits at the end of the GNT cycle.
  - Maximum throughput: one write per 2 cycles, one read per 3 cycles.
- rdata holds its value until the next read capture. rvalid is never asserted for writes.
- Arbitration is evaluated in IDLE only. The arbitration cycle following RD is the same cycle in which rvalid is high, so back-to-back reads overlap by that cycle.
- Request withdrawal:
  - A requester may drop req before gnt. Only requests high in an IDLE cycle are considered.
  - After gnt, the requester must drop req (or present a new request) by the next IDLE cycle.
  - A req still high in IDLE is treated as a new access.
- dbg_lock:
  - Sampled in IDLE only.
  - Asserting it during GNT/RD does not abort a CPU access already granted.
- Only one gnt and at most one rvalid are high in any cycle. cpu_gnt and dbg_gnt are never simultaneously 1.
- busy = (state != IDLE).

Test Plan:
- Reset then CPU read: mem preloaded M[0x10]=0xBEEF; cpu_req=1, cpu_we=0, cpu_addr=0x10 -> cpu_gnt at cycle+1, mem_en=1 with mem_addr=0x10; cpu_rvalid at cycle+3 with rdata=0xBEEF; dbg_* outputs stay 0.
- Debug write: dbg_req=1, dbg_we=1, dbg_addr=0x20, dbg_wdata=0x1234 -> dbg_gnt at cycle+1 with mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x1234; no rvalid; a subsequent debug read of 0x20 returns 0x1234.
- Simultaneous requests held continuously, 4 accesses -> grants alternate CPU, DBG, CPU, DBG (CPU first after reset); no requester starves.
- dbg_lock=1 with both requesting -> only dbg is granted; cpu_gnt stays 0 until dbg_lock=0 is sampled in IDLE, then the CPU is granted.
- Reset asserted during RD of a CPU read -> all outputs 0 immediately; no cpu_rvalid after reset release; the next access proceeds normally from IDLE.
- Request withdrawn: cpu_req pulsed high only during a cycle when busy=1, then dropped before IDLE -> no cpu_gnt, no mem_en, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the CPU and a
//   debug/loader port. Each access is sequenced as IDLE -> GNT (-> RD for
//   reads) -> IDLE. When both requesters are eligible, the grant alternates
//   between them.
//
// Ports
//   clk, reset                     clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata          CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid            CPU grant pulse / read-data-valid pulse
//   dbg_req/we/addr/wdata          debug request (held until dbg_gnt)
//   dbg_lock                       locks the CPU out of arbitration
//   dbg_gnt, dbg_rvalid            debug grant pulse / read-data-valid pulse
//   rdata                          registered read data, shared
//   mem_en/we/addr/wdata           registered memory command
//   mem_rdata                      memory read data, valid one cycle after a read
//   busy                           high whenever an access is in progress
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        RD   = 2'd2
    } state_t;

    // Requester identity, used for both owner and last_gnt.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              owner_q, owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              dbg_gnt_q, dbg_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic cpu_elig;
    logic dbg_elig;
    logic pick_dbg;

    assign cpu_elig = cpu_req & ~dbg_lock;
    assign dbg_elig = dbg_req;
    // Debug wins when it is alone, or on a tie when the CPU had the last grant.
    assign pick_dbg = dbg_elig & (~cpu_elig | (last_gnt_q == OWN_CPU));

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        owner_d      = owner_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_elig | dbg_elig) begin
                    state_d    = GNT;
                    mem_en_d   = 1'b1;
                    owner_d    = pick_dbg;
                    last_gnt_d = pick_dbg;
                    if (pick_dbg) begin
                        mem_we_d    = dbg_we;
                        mem_addr_d  = dbg_addr;
                        mem_wdata_d = dbg_wdata;
                        dbg_gnt_d   = 1'b1;
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        cpu_gnt_d   = 1'b1;
                    end
                end
            end
            GNT: begin
                // The write commits at the end of this cycle; a read still
                // needs one cycle for the memory to return data.
                state_d = mem_we_q ? IDLE : RD;
            end
            RD: begin
                rdata_d      = mem_rdata;
                cpu_rvalid_d = (owner_q == OWN_CPU);
                dbg_rvalid_d = (owner_q == OWN_DBG);
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_gnt_q   <= OWN_DBG;   // CPU wins the first tie
            owner_q      <= OWN_CPU;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            owner_q      <= owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dbg_gnt    = dbg_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign rdata      = rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q != IDLE);

endmodule
